// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, per-channel debounce counter, clean level and press/release strobes.
// Build option BTN_DEBOUNCE_ACTIVE_LOW_EN inverts the pins so that pin low reads as pressed.
module btn_debounce #(
  parameter int unsigned WIDTH           = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] released
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] pins;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_nx   [WIDTH];
  logic [WIDTH-1:0] level_nx;
  logic [WIDTH-1:0] press_nx;
  logic [WIDTH-1:0] released_nx;

  // Pin polarity: internal logic always works with 1 = pressed.
`ifdef BTN_DEBOUNCE_ACTIVE_LOW_EN
  assign pins = ~btn;
`else
  assign pins = btn;
`endif

  // Synchroniser, counters and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      level    <= '0;
      press    <= '0;
      released <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1       <= pins;
      s2       <= s1;
      level    <= level_nx;
      press    <= press_nx;
      released <= released_nx;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nx[i];
      end
    end
  end

  // Debounce decision: a differing sample advances the count, a matching one restarts it.
  always_comb begin
    level_nx    = level;
    press_nx    = '0;
    released_nx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_nx[i] = cnt[i];
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s2[i] == level[i]) begin
        cnt_nx[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        level_nx[i]    = s2[i];
        cnt_nx[i]      = '0;
        press_nx[i]    = s2[i];
        released_nx[i] = ~s2[i];
      end else begin
        cnt_nx[i] = cnt[i] + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing, compared every cycle against a sample-window model.
module tb_btn_debounce;

  localparam int unsigned WIDTH = 7;
  localparam int          D     = 4;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] btn;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] released;

  btn_debounce #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .btn      (btn),
    .level    (level),
    .press    (press),
    .released (released)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state: logical (1 = pressed) button vector, synchroniser stages, window of synchronised samples.
  logic [WIDTH-1:0] lb;
  logic [WIDTH-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  logic [WIDTH-1:0] hist[$];

  function automatic logic [WIDTH-1:0] phys(input logic [WIDTH-1:0] v);
`ifdef BTN_DEBOUNCE_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare away from the edge.
  task automatic step(input logic [WIDTH-1:0] logical, input logic rst);
    bit ok;
    lb    = logical;
    btn   = phys(logical);
    reset = rst;
    @(posedge clock);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (hist.size() == D) begin
          ok = 1'b1;
          foreach (hist[j]) if (hist[j][i] == m_level[i]) ok = 1'b0;
          if (ok) begin
            m_level[i] = ~m_level[i];
            m_press[i] = m_level[i];
            m_rel[i]   = ~m_level[i];
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = logical;
    end
    #1;
    chk("level",    32'(level),    32'(m_level));
    chk("press",    32'(press),    32'(m_press));
    chk("release",  32'(released), 32'(m_rel));
    chk("exclusive", 32'(press & released), 32'd0);
  endtask

  initial begin
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
    lb = '0;
    btn = phys('0);
    reset = 1'b1;

    // Reset held 3 cycles with no button pressed.
    repeat (3) step('0, 1'b1);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_strobes", 32'(press | released), 32'd0);
    step('0, 1'b0);
    step('0, 1'b0);

    // Clean press on channel 5: visible after edge k+5.
    repeat (5) step(7'h20, 1'b0);
    chk("press5_early", 32'(level[5]), 32'd0);
    step(7'h20, 1'b0);
    chk("press5_level", 32'(level), 32'h20);
    chk("press5_strobe", 32'(press), 32'h20);
    step(7'h20, 1'b0);
    chk("press5_oneshot", 32'(press), 32'd0);

    // Bouncing channel 4, then held high.
    step(7'h30, 1'b0);
    step(7'h20, 1'b0);
    step(7'h30, 1'b0);
    step(7'h20, 1'b0);
    repeat (5) begin
      step(7'h30, 1'b0);
      chk("bounce_quiet", 32'(press[4]), 32'd0);
    end
    step(7'h30, 1'b0);
    chk("bounce_press4", 32'(press), 32'h10);
    repeat (2) step(7'h30, 1'b0);

    // Channel 6 pressed, then released together with channel 0 press.
    repeat (7) step(7'h70, 1'b0);
    chk("ch6_pressed", 32'(level[6]), 32'd1);
    repeat (5) step(7'h31, 1'b0);
    step(7'h31, 1'b0);
    chk("simul_press0", 32'(press), 32'h01);
    chk("simul_release6", 32'(released), 32'h40);
    chk("simul_level", 32'(level), 32'h31);
    step(7'h31, 1'b0);

    // Reset pulse mid-count on channel 2 (other channels return to idle through reset).
    step(7'h04, 1'b1);
    step(7'h04, 1'b0);
    repeat (3) step(7'h04, 1'b0);
    step(7'h04, 1'b1);
    chk("midreset_level", 32'(level[2]), 32'd0);
    repeat (5) begin
      step(7'h04, 1'b0);
      chk("midreset_wait", 32'(level[2]), 32'd0);
    end
    step(7'h04, 1'b0);
    chk("midreset_press2", 32'(press), 32'h04);

    // Idle through reset gives no strobes; then channel 1 pressed.
    repeat (2) step('0, 1'b1);
    repeat (3) begin
      step('0, 1'b0);
      chk("idle_no_strobe", 32'(press | released), 32'd0);
    end
    repeat (5) step(7'h02, 1'b0);
    step(7'h02, 1'b0);
    chk("press1", 32'(press), 32'h02);

    // Random bouncing with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic [WIDTH-1:0] nxt;
      nxt = lb;
      for (int i = 0; i < int'(WIDTH); i++)
        if ($urandom_range(5, 0) == 0) nxt[i] = ~nxt[i];
      step(nxt, ($urandom_range(99, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
